// File: rtl/mem_router_pkg.sv
// ============================================================================
// mem_router_pkg : shared types, default address map and helpers for mem_router
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_router_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] uintx_t;

  localparam int unsigned N_TGT = 3;

  typedef enum logic [1:0] {
    T_RAM   = 2'd0,
    T_CLINT = 2'd1,
    T_UART  = 2'd2
  } mem_target_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } router_state_e;

  localparam addr_t DEF_RAM_BASE   = 32'h8000_0000;
  localparam addr_t DEF_RAM_LAST   = 32'h8FFF_FFFF;
  localparam addr_t DEF_CLINT_BASE = 32'h0200_0000;
  localparam addr_t DEF_CLINT_LAST = 32'h0200_FFFF;
  localparam addr_t DEF_UART_BASE  = 32'h1000_0000;
  localparam addr_t DEF_UART_LAST  = 32'h1000_00FF;

  function automatic logic x_in_range(input addr_t a, input addr_t base, input addr_t last);
    return (a >= base) && (a <= last);
  endfunction

  function automatic logic ialigned(input addr_t a);
    return a[1:0] == 2'b00;
  endfunction

  function automatic logic ranges_overlap(input addr_t b0, input addr_t l0,
                                          input addr_t b1, input addr_t l1);
    return (b0 <= l1) && (b1 <= l0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_router_decoder.sv
// ============================================================================
// mem_addr_decoder : combinational address-map and alignment decode
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_addr_decoder
  import mem_router_pkg::*;
#(
  parameter addr_t RAM_BASE   = DEF_RAM_BASE,
  parameter addr_t RAM_LAST   = DEF_RAM_LAST,
  parameter addr_t CLINT_BASE = DEF_CLINT_BASE,
  parameter addr_t CLINT_LAST = DEF_CLINT_LAST,
  parameter addr_t UART_BASE  = DEF_UART_BASE,
  parameter addr_t UART_LAST  = DEF_UART_LAST
) (
  input  addr_t       addr_i,
  input  mem_size_e   size_i,
  output logic        hit_o,
  output mem_target_e tgt_o,
  output logic        misaligned_o
);

  if (RAM_BASE > RAM_LAST || CLINT_BASE > CLINT_LAST || UART_BASE > UART_LAST) begin : g_chk_order
    $fatal(1, "mem_addr_decoder: a range has BASE > LAST");
  end
  if (ranges_overlap(RAM_BASE, RAM_LAST, CLINT_BASE, CLINT_LAST) ||
      ranges_overlap(RAM_BASE, RAM_LAST, UART_BASE, UART_LAST) ||
      ranges_overlap(CLINT_BASE, CLINT_LAST, UART_BASE, UART_LAST)) begin : g_chk_overlap
    $fatal(1, "mem_addr_decoder: address ranges overlap");
  end

  logic w_ram_hit;
  logic w_clint_hit;
  logic w_uart_hit;

  assign w_ram_hit   = x_in_range(addr_i, RAM_BASE, RAM_LAST);
  assign w_clint_hit = x_in_range(addr_i, CLINT_BASE, CLINT_LAST);
  assign w_uart_hit  = x_in_range(addr_i, UART_BASE, UART_LAST);

  always_comb begin
    hit_o        = w_ram_hit | w_clint_hit | w_uart_hit;
    tgt_o        = T_RAM;
    misaligned_o = 1'b0;
    if (w_ram_hit) begin
      tgt_o = T_RAM;
    end else if (w_clint_hit) begin
      tgt_o = T_CLINT;
    end else if (w_uart_hit) begin
      tgt_o = T_UART;
    end
    // Only the first byte is range-checked; alignment covers the rest.
    case (size_i)
      SZ_B:    misaligned_o = 1'b0;
      SZ_H:    misaligned_o = addr_i[0];
      SZ_W:    misaligned_o = !ialigned(addr_i);
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_router.sv
// ============================================================================
// mem_router : routes one data-memory request port to RAM / CLINT / UART
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_router
  import mem_router_pkg::*;
#(
  parameter addr_t RAM_BASE   = DEF_RAM_BASE,
  parameter addr_t RAM_LAST   = DEF_RAM_LAST,
  parameter addr_t CLINT_BASE = DEF_CLINT_BASE,
  parameter addr_t CLINT_LAST = DEF_CLINT_LAST,
  parameter addr_t UART_BASE  = DEF_UART_BASE,
  parameter addr_t UART_LAST  = DEF_UART_LAST
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  addr_t                        req_addr_i,
  input  logic                         req_wen_i,
  input  mem_size_e                    req_size_i,
  input  uintx_t                       req_wdata_i,
  input  logic [3:0]                   req_wmask_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output uintx_t                       resp_rdata_o,
  output logic                         resp_err_o,
  output logic [N_TGT-1:0]             tgt_req_valid_o,
  input  logic [N_TGT-1:0]             tgt_req_ready_i,
  output addr_t                        tgt_addr_o,
  output logic                         tgt_wen_o,
  output uintx_t                       tgt_wdata_o,
  output logic [3:0]                   tgt_wmask_o,
  input  logic [N_TGT-1:0]             tgt_resp_valid_i,
  input  logic [N_TGT-1:0][31:0]       tgt_resp_rdata_i,
  output logic                         stray_resp_o
);

  router_state_e state_q, state_d;
  addr_t         addr_q, addr_d;
  logic          wen_q, wen_d;
  uintx_t        wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  mem_target_e   tgt_q, tgt_d;
  uintx_t        rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          stray_q, stray_d;

  logic             dec_hit;
  mem_target_e      dec_tgt;
  logic             dec_misaligned;
  logic [N_TGT-1:0] w_tgt_onehot;
  logic [N_TGT-1:0] w_awaited;
  logic             w_tgt_resp;

  mem_addr_decoder #(
    .RAM_BASE   (RAM_BASE),
    .RAM_LAST   (RAM_LAST),
    .CLINT_BASE (CLINT_BASE),
    .CLINT_LAST (CLINT_LAST),
    .UART_BASE  (UART_BASE),
    .UART_LAST  (UART_LAST)
  ) u_dec (
    .addr_i       (req_addr_i),
    .size_i       (req_size_i),
    .hit_o        (dec_hit),
    .tgt_o        (dec_tgt),
    .misaligned_o (dec_misaligned)
  );

  assign w_tgt_onehot = N_TGT'(1) << tgt_q;
  assign w_tgt_resp   = tgt_resp_valid_i[tgt_q];
  assign w_awaited    = ((state_q == S_ISSUE && tgt_req_ready_i[tgt_q]) || state_q == S_WAIT)
                        ? w_tgt_onehot : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      tgt_q   <= T_RAM;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      tgt_q   <= tgt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      stray_q <= stray_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    tgt_d           = tgt_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    stray_d         = stray_q | (|(tgt_resp_valid_i & ~w_awaited));
    req_ready_o     = 1'b0;
    tgt_req_valid_o = '0;
    resp_valid_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wen_d   = req_wen_i;
          wdata_d = req_wdata_i;
          wmask_d = req_wmask_i;
          tgt_d   = dec_tgt;
          if (!dec_hit || dec_misaligned) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tgt_req_valid_o = w_tgt_onehot;
        if (tgt_req_ready_i[tgt_q]) begin
          // A target may answer in the very cycle it accepts the request.
          if (w_tgt_resp) begin
            rdata_d = wen_q ? '0 : tgt_resp_rdata_i[tgt_q];
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_tgt_resp) begin
          rdata_d = wen_q ? '0 : tgt_resp_rdata_i[tgt_q];
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign resp_err_o   = resp_valid_o & err_q;
  assign tgt_addr_o   = addr_q;
  assign tgt_wen_o    = wen_q;
  assign tgt_wdata_o  = wdata_q;
  assign tgt_wmask_o  = wmask_q;
  assign stray_resp_o = stray_q;

endmodule

`default_nettype wire
